// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional odd parity, one stop bit,
// sampled mid-bit at OVS x the bit rate; result held until the host reads it.
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ChkEn,
  input  logic       RxD,
  input  logic       rd,
  output logic [7:0] dat,
  output logic       busy,
  output logic       RINT,
  output logic       PERR,
  output logic       FERR,
  output logic       OERR
);

  localparam int            CW       = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          s1, s2, rxs;
  logic [CW-1:0] ovs_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          chk, pbit;
  logic          cnt_last, cnt_half;
  logic          start_det, data_tick, par_tick, done;

  // Two-flop synchronizer; the line idles high, so both flops reset to 1.
  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what turns s1 -> s2 into a real two-stage pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= RxD;
      s2 <= s1;
    end
  end

  assign rxs      = s2;
  assign cnt_last = (ovs_cnt == CNT_LAST);
  assign cnt_half = (ovs_cnt == CNT_HALF);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_nxt = state;
    start_det = 1'b0;
    data_tick = 1'b0;
    par_tick  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !rxs) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        // A line back high at mid start bit was only a glitch.
        if (cnt_half) state_nxt = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_last) begin
          data_tick = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = chk ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt_last) begin
          par_tick  = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt_last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The oversample counter restarts on every state change and at each bit end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovs_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      chk     <= 1'b0;
      pbit    <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt != state || cnt_last) ovs_cnt <= '0;
      else                                                 ovs_cnt <= ovs_cnt + CW'(1);
      if (start_det) chk <= ChkEn;
      if (state == START)  bit_cnt <= 3'd0;
      else if (data_tick)  bit_cnt <= bit_cnt + 3'd1;
      if (data_tick) shift <= {rxs, shift[7:1]};
      if (par_tick)  pbit  <= rxs;
    end
  end

  // Completion takes priority over a coincident read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat  <= 8'h00;
      busy <= 1'b0;
      RINT <= 1'b0;
      PERR <= 1'b0;
      FERR <= 1'b0;
      OERR <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (done) begin
        dat  <= shift;
        FERR <= ~rxs;
        PERR <= chk & ~(^{pbit, shift});
        RINT <= 1'b1;
        OERR <= RINT & ~rd;
      end else if (rd) begin
        RINT <= 1'b0;
        OERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, a frame-level reference model checked
// every cycle, plus literal expectations on bytes, flags and latencies.
module tb_uart_rx;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       ChkEn = 1'b0;
  logic       RxD = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       busy, RINT, PERR, FERR, OERR;

  uart_rx #(.OVS(OVS)) dut (
    .clk(clk), .rst(rst), .en(en), .ChkEn(ChkEn), .RxD(RxD), .rd(rd),
    .dat(dat), .busy(busy), .RINT(RINT), .PERR(PERR), .FERR(FERR), .OERR(OERR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One entry per expected receiver activity: busy window [e0+2, last) and,
  // for real frames, the outcome applied at edge 'last'.
  typedef struct {
    int         e0;
    int         last;
    bit         done;
    logic [7:0] b;
    bit         ferr;
    bit         perr;
  } frame_t;

  frame_t     fq[$];
  int         cyc = 0;
  int         last_e0 = 0;
  int         rint_rise = -1;
  bit         prev_rint = 1'b0;
  logic [7:0] m_dat = 8'h00;
  bit         m_busy = 1'b0, m_rint = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_oerr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      m_dat  = 8'h00;
      m_busy = 1'b0;
      m_rint = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_oerr = 1'b0;
    end else begin
      cyc++;
      if (fq.size() > 0 && fq[0].last == cyc) begin
        if (fq[0].done) begin
          m_dat  = fq[0].b;
          m_ferr = fq[0].ferr;
          m_perr = fq[0].perr;
          m_oerr = m_rint && !rd;
          m_rint = 1'b1;
        end else if (rd) begin
          m_rint = 1'b0;
          m_oerr = 1'b0;
        end
        void'(fq.pop_front());
      end else if (rd) begin
        m_rint = 1'b0;
        m_oerr = 1'b0;
      end
      m_busy = (fq.size() > 0) && (cyc >= fq[0].e0 + 2) && (cyc < fq[0].last);
    end
  end

  always @(posedge clk) begin
    #1;
    check("outputs{busy,RINT,PERR,FERR,OERR,dat}",
          {19'd0, busy, RINT, PERR, FERR, OERR, dat},
          {19'd0, m_busy, m_rint, m_perr, m_ferr, m_oerr, m_dat});
    if (!prev_rint && RINT) rint_rise = cyc;
    prev_rint = RINT;
  end

  // Drives a frame bit by bit from a negedge; cut>0 stops after that many bits.
  task automatic send_frame(input logic [7:0] b, input bit par, input bit pb,
                            input bit stop, input int cut, input bit expect_rx);
    logic [10:0] bits;
    int          nbits;
    frame_t      f;
    @(negedge clk);
    last_e0 = cyc + 1;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (par) begin
      bits[9]  = pb;
      bits[10] = stop;
      nbits    = 11;
    end else begin
      bits[9] = stop;
      nbits   = 10;
    end
    if (expect_rx) begin
      f.e0   = last_e0;
      f.last = last_e0 + 2 + OVS / 2 + (par ? 10 : 9) * OVS;
      f.done = 1'b1;
      f.b    = b;
      f.ferr = !stop;
      f.perr = par && ((($countones(b) + int'(pb)) % 2) == 0);
      fq.push_back(f);
      if (!stop) begin
        // A low stop bit is still on the line when IDLE is re-entered.
        f.e0   = f.last - 1;
        f.last = f.e0 + 2 + OVS / 2;
        f.done = 1'b0;
        fq.push_back(f);
      end
    end
    for (int i = 0; i < ((cut > 0) ? cut : nbits); i++) begin
      RxD = bits[i];
      repeat (OVS) @(negedge clk);
    end
    if (cut == 0) RxD = 1'b1;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    frame_t g;
    int     guard;

    idle(3);
    check("reset_dat", {24'd0, dat}, 32'h00);
    check("reset_flags", {27'd0, busy, RINT, PERR, FERR, OERR}, 32'h0);
    rst = 1'b1;
    idle(5);

    // Basic frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    check("basic_dat", {24'd0, dat}, 32'hA5);
    check("basic_perr_ferr", {30'd0, PERR, FERR}, 32'h0);
    check("basic_rint", {31'd0, RINT}, 32'h1);
    check("basic_latency", rint_rise - last_e0, 154);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rd_clears_rint", {31'd0, RINT}, 32'h0);

    // Reset mid-frame with a byte pending
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    idle(4);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 5, 1'b1);
    check("pre_reset_busy", {31'd0, busy}, 32'h1);
    rst = 1'b0;
    RxD = 1'b1;
    #1;
    check("midreset_dat", {24'd0, dat}, 32'h00);
    check("midreset_flags", {27'd0, busy, RINT, PERR, FERR, OERR}, 32'h0);
    idle(2);
    rst = 1'b1;
    idle(5);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    check("after_reset_dat", {24'd0, dat}, 32'h3C);
    check("after_reset_rint", {31'd0, RINT}, 32'h1);
    rd_pulse();
    idle(3);

    // Parity frames
    ChkEn = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    check("par_00_p1_perr", {31'd0, PERR}, 32'h0);
    check("par_latency", rint_rise - last_e0, 170);
    rd_pulse();
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    check("par_00_p0_perr", {31'd0, PERR}, 32'h1);
    rd_pulse();
    fork
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, 1'b1);
      begin
        idle(40);
        ChkEn = 1'b0;
      end
    join
    check("par_07_p0_perr", {31'd0, PERR}, 32'h0);
    check("par_07_dat", {24'd0, dat}, 32'h07);
    rd_pulse();
    idle(3);

    // Framing error
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(20);
    check("ferr_flag", {31'd0, FERR}, 32'h1);
    check("ferr_dat", {24'd0, dat}, 32'h55);
    rd_pulse();
    idle(3);

    // Glitch on idle line
    @(negedge clk);
    g.e0   = cyc + 1;
    g.last = g.e0 + 2 + OVS / 2;
    g.done = 1'b0;
    g.b    = 8'h00;
    g.ferr = 1'b0;
    g.perr = 1'b0;
    fq.push_back(g);
    RxD = 1'b0;
    idle(3);
    RxD = 1'b1;
    idle(20);
    check("glitch_rint", {31'd0, RINT}, 32'h0);
    check("glitch_busy", {31'd0, busy}, 32'h0);

    // Overrun
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    check("ovr_dat", {24'd0, dat}, 32'h22);
    check("ovr_oerr", {31'd0, OERR}, 32'h1);
    rd_pulse();
    check("ovr_rd_clears", {30'd0, RINT, OERR}, 32'h0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      begin
        idle(2);
        guard = 0;
        while (cyc != last_e0 + 153 && guard < 400) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 400) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_align: timed out waiting for completion edge");
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    check("coincide_rint_oerr", {30'd0, RINT, OERR}, 32'h2);
    check("coincide_dat", {24'd0, dat}, 32'h22);
    rd_pulse();
    idle(3);

    // Enable gating
    en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle(5);
    en = 1'b1;
    check("en_off_rint", {31'd0, RINT}, 32'h0);
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      begin
        idle(40);
        en = 1'b0;
      end
    join
    idle(3);
    en = 1'b1;
    check("en_drop_dat", {24'd0, dat}, 32'hC3);
    check("en_drop_rint", {31'd0, RINT}, 32'h1);
    rd_pulse();
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
